// File: rtl/nonce_result_scanner.sv
// nonce_result_scanner: reads back the nonce-sweep H0 table and reports hits, best hash/nonce and hit count.
// Optional macro SCAN_EARLY_EXIT_EN: stop the scan on the first H0 below target.
module nonce_result_scanner #(
    parameter int NUM_NONCES = 16,
    parameter int ADDR_W     = 16,
    parameter int RD_LAT     = 1,
    localparam int NONCE_W   = (NUM_NONCES > 1) ? $clog2(NUM_NONCES) : 1,
    localparam int CNT_W     = $clog2(NUM_NONCES + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  result_addr,
    input  logic [31:0]        target,
    output logic               done,
    output logic               found,
    output logic [NONCE_W-1:0] best_nonce,
    output logic [31:0]        best_hash,
    output logic [CNT_W-1:0]   hit_count,
    output logic               mem_clk,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [31:0]        mem_write_data,
    input  logic [31:0]        mem_read_data
);

`ifdef SCAN_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     issue_cnt_reg;
    logic [NONCE_W-1:0]   cap_cnt_reg;
    logic [RD_LAT:0]      tag_reg;
    logic [31:0]          target_reg;
    logic [ADDR_W-1:0]    mem_addr_reg;
    logic                 done_reg;
    logic                 found_reg;
    logic [NONCE_W-1:0]   best_nonce_reg;
    logic [31:0]          best_hash_reg;
    logic [CNT_W-1:0]     hit_count_reg;

    logic cap_valid, is_hit, last_cap, stop_scan;
    logic load_en, step_en, cap_en, tag_flush;

    // The oldest tag marks the cycle in which mem_read_data holds an issued word.
    assign cap_valid = tag_reg[RD_LAT];
    assign is_hit    = mem_read_data < target_reg;
    assign last_cap  = cap_cnt_reg == NONCE_W'(NUM_NONCES - 1);
    assign stop_scan = cap_valid && (last_cap || (EARLY_EXIT && is_hit));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) state_next = S_ISSUE;
            end
            S_ISSUE: begin
                if (stop_scan)
                    state_next = S_IDLE;
                else if (issue_cnt_reg == CNT_W'(NUM_NONCES))
                    state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (stop_scan) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        load_en   = 1'b0;
        step_en   = 1'b0;
        cap_en    = 1'b0;
        tag_flush = (state_next == S_IDLE);
        case (state_reg)
            S_IDLE:  load_en = start;
            S_ISSUE: begin
                step_en = (state_next == S_ISSUE);
                cap_en  = cap_valid;
            end
            S_DRAIN: cap_en = cap_valid;
            default: ;
        endcase
    end

    // Address issue and capture bookkeeping; leaving the scan discards in-flight tags.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_reg       <= '0;
            mem_addr_reg  <= '0;
            issue_cnt_reg <= '0;
            cap_cnt_reg   <= '0;
            target_reg    <= '0;
        end else begin
            tag_reg <= tag_flush ? '0 : {tag_reg[RD_LAT-1:0], load_en | step_en};
            if (load_en) begin
                mem_addr_reg  <= result_addr;
                issue_cnt_reg <= CNT_W'(1);
                cap_cnt_reg   <= '0;
                target_reg    <= target;
            end else begin
                if (step_en) begin
                    mem_addr_reg  <= mem_addr_reg + ADDR_W'(1);
                    issue_cnt_reg <= issue_cnt_reg + CNT_W'(1);
                end
                if (cap_en) cap_cnt_reg <= cap_cnt_reg + NONCE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done_reg       <= 1'b1;
            found_reg      <= 1'b0;
            best_nonce_reg <= '0;
            best_hash_reg  <= '1;
            hit_count_reg  <= '0;
        end else begin
            done_reg <= (state_reg == S_IDLE);
            if (load_en) begin
                found_reg      <= 1'b0;
                best_nonce_reg <= '0;
                best_hash_reg  <= '1;
                hit_count_reg  <= '0;
            end else if (cap_en) begin
                if (EARLY_EXIT && is_hit) begin
                    // A first hit is necessarily below every earlier non-hit word.
                    found_reg      <= 1'b1;
                    hit_count_reg  <= CNT_W'(1);
                    best_nonce_reg <= cap_cnt_reg;
                    best_hash_reg  <= mem_read_data;
                end else begin
                    if (is_hit) begin
                        found_reg <= 1'b1;
                        if (hit_count_reg != CNT_W'(NUM_NONCES))
                            hit_count_reg <= hit_count_reg + CNT_W'(1);
                    end
                    if (mem_read_data < best_hash_reg) begin
                        best_nonce_reg <= cap_cnt_reg;
                        best_hash_reg  <= mem_read_data;
                    end
                end
            end
        end
    end

    assign done           = done_reg;
    assign found          = found_reg;
    assign best_nonce     = best_nonce_reg;
    assign best_hash      = best_hash_reg;
    assign hit_count      = hit_count_reg;
    assign mem_clk        = clk;
    assign mem_we         = 1'b0;
    assign mem_addr       = mem_addr_reg;
    assign mem_write_data = '0;

endmodule

// File: tb/tb_nonce_result_scanner.sv
// Scoreboard bench for nonce_result_scanner: directed tables, expected results queued at start, checked when done rises.
module tb_nonce_result_scanner;

    localparam int N      = 16;
    localparam int AW     = 16;
    localparam int RD_LAT = 1;
    localparam int FULL_LAT = N + RD_LAT + 1;

`ifdef SCAN_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    typedef struct {
        string       name;
        bit          found;
        int          hits;
        int          nonce;
        logic [31:0] hash;
        int          lat;
        int          start_cyc;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          start;
    logic [AW-1:0] result_addr;
    logic [31:0]   target;
    logic          done, found;
    logic [3:0]    best_nonce;
    logic [31:0]   best_hash;
    logic [4:0]    hit_count;
    logic          mem_clk, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_write_data;
    logic [31:0]   mem_read_data;

    logic [31:0] mem [0:65535];
    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        rst_q = 1'b1;
    logic        done_prev;
    bit          we_seen = 1'b0;

    nonce_result_scanner #(.NUM_NONCES(N), .ADDR_W(AW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .result_addr(result_addr), .target(target),
        .done(done), .found(found), .best_nonce(best_nonce), .best_hash(best_hash),
        .hit_count(hit_count), .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
        mem_read_data <= mem[mem_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    function automatic exp_t mk(input string nm, input bit f, input int h, input int n,
                                input logic [31:0] hs, input int l);
        exp_t e;
        e.name = nm; e.found = f; e.hits = h; e.nonce = n; e.hash = hs; e.lat = l; e.start_cyc = 0;
        return e;
    endfunction

    // Reference scan over the bench memory (used for the wrap-around table).
    function automatic exp_t ref_scan(input string nm, input logic [15:0] base, input logic [31:0] tgt);
        exp_t e;
        logic [31:0] h;
        e = mk(nm, 1'b0, 0, 0, 32'hFFFF_FFFF, FULL_LAT);
        for (int i = 0; i < N; i++) begin
            h = mem[16'(base + 16'(i))];
            if (h < tgt) begin
                e.found = 1'b1;
                if (EE) begin
                    e.hits = 1; e.nonce = i; e.hash = h; e.lat = i + RD_LAT + 2;
                    break;
                end
                e.hits++;
            end
            if (h < e.hash) begin
                e.hash = h; e.nonce = i;
            end
        end
        return e;
    endfunction

    // Monitor: one transaction line per completed scan.
    always @(negedge clk) begin
        if (mem_we !== 1'b0) we_seen = 1'b1;
        if (!rst_q && done === 1'b1 && done_prev === 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done rose at cycle %0d with no scan pending", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                $display("scan %s: found=%0d hits=%0d nonce=%0d hash=%08h latency=%0d",
                         mon_e.name, found, hit_count, best_nonce, best_hash, cyc - mon_e.start_cyc);
                chk({mon_e.name, "_found"}, 32'(found), 32'(mon_e.found));
                chk({mon_e.name, "_hits"}, 32'(hit_count), 32'(mon_e.hits));
                chk({mon_e.name, "_nonce"}, 32'(best_nonce), 32'(mon_e.nonce));
                chk({mon_e.name, "_hash"}, best_hash, mon_e.hash);
                chk({mon_e.name, "_latency"}, 32'(cyc - mon_e.start_cyc), 32'(mon_e.lat));
                chk({mon_e.name, "_mem_we"}, 32'(we_seen), 32'd0);
                we_seen = 1'b0;
            end
        end
        done_prev = done;
    end

    // Called at a negedge; returns at the negedge after the start edge.
    task automatic run_scan(input exp_t e, input logic [15:0] base, input logic [31:0] tgt, input bit push);
        exp_t ee;
        ee = e;
        start = 1'b1; result_addr = base; target = tgt;
        ee.start_cyc = cyc + 1;
        if (push) exp_q.push_back(ee);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || done !== 1'b1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: scan not complete after 200 cycles, pending=%0d", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic chk_reset_state(input string pfx);
        chk({pfx, "_done"}, 32'(done), 32'd1);
        chk({pfx, "_found"}, 32'(found), 32'd0);
        chk({pfx, "_hits"}, 32'(hit_count), 32'd0);
        chk({pfx, "_nonce"}, 32'(best_nonce), 32'd0);
        chk({pfx, "_hash"}, best_hash, 32'hFFFF_FFFF);
        chk({pfx, "_mem_addr"}, 32'(mem_addr), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; start = 1'b0; result_addr = '0; target = '0;
        for (int i = 0; i < N; i++) begin
            mem[16'h0100 + i] = 32'h1000_0000 + 32'(i);
            mem[16'h0200 + i] = (i == 9) ? 32'h0000_00FF : 32'h8000_0000;
            mem[16'h0300 + i] = 32'hFFFF_FFFF;
            mem[16'h0400 + i] = (i == 3) ? 32'h0000_0050 : (i == 7) ? 32'h0000_0010 : 32'h9000_0000;
            mem[16'h0500 + i] = 32'h0000_0000;
            mem[16'h0600 + i] = 32'h0000_1000 * 32'(16 - i);
            mem[16'(16'hFFF8 + 16'(i))] = {4'h7, 4'(15 - i), 24'(i * 37)};
        end

        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        chk("reset_mem_we", 32'(mem_we), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_scan(EE ? mk("ramp", 1, 1, 0, 32'h1000_0000, 3)
                    : mk("ramp", 1, 5, 0, 32'h1000_0000, FULL_LAT), 16'h0100, 32'h1000_0005, 1'b1);
        wait_idle();

        // A start pulse while busy must not disturb the scan in flight.
        run_scan(EE ? mk("single_hit", 1, 1, 9, 32'h0000_00FF, 12)
                    : mk("single_hit", 1, 1, 9, 32'h0000_00FF, FULL_LAT), 16'h0200, 32'h0000_0100, 1'b1);
        repeat (4) @(negedge clk);
        start = 1'b1; result_addr = 16'h0100; target = 32'h0;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        run_scan(mk("all_ff_t0", 0, 0, 0, 32'hFFFF_FFFF, FULL_LAT), 16'h0300, 32'h0, 1'b1);
        wait_idle();
        run_scan(mk("all_ff_t1", 0, 0, 0, 32'hFFFF_FFFF, FULL_LAT), 16'h0300, 32'h1, 1'b1);
        wait_idle();

        run_scan(EE ? mk("two_hits", 1, 1, 3, 32'h0000_0050, 6)
                    : mk("two_hits", 1, 2, 7, 32'h0000_0010, FULL_LAT), 16'h0400, 32'h0000_0100, 1'b1);
        wait_idle();

        // Address wrap: check the issued address on each edge of the issue phase.
        run_scan(ref_scan("wrap", 16'hFFF8, 32'h7800_0000), 16'hFFF8, 32'h7800_0000, 1'b1);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("wrap_addr%0d", i), 32'(mem_addr), 32'(16'(16'hFFF8 + 16'(i))));
            @(negedge clk);
        end
        wait_idle();

        // Reset on cycle 6 of a scan, then a fresh scan on a different table.
        run_scan(mk("aborted", 0, 0, 0, 32'h0, 0), 16'h0500, 32'hFFFF_FFFF, 1'b0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_state("midreset");
        reset = 1'b0;
        @(negedge clk);
        run_scan(EE ? mk("after_reset", 1, 1, 13, 32'h0000_3000, 16)
                    : mk("after_reset", 1, 3, 15, 32'h0000_1000, FULL_LAT), 16'h0600, 32'h0000_3001, 1'b1);
        wait_idle();

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
